pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
- Pipeline control unit that sequences the fetch PC register and the downstream pipeline latches.
- Merges per-stage stall requests into the 6-bit stall vector.
- Accepts exception and ERET requests from the MEM stage through a req/ack handshake, waits for the memory bus to go quiet, then issues a one-cycle flush with the redirect address (new_pc).
- Sits beside the datapath; drives stall[5:0], flush and new_pc into PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
- EXC_VECTOR, 32'hBFC00380, redirect target for every exception.
- RECOVER_CYC, 1, cycles after a flush during which new exception/ERET requests are not accepted (range 1..7).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stallreq_if  input  1  fetch-stage stall request.
- stallreq_id  input  1  decode-stage stall request.
- stallreq_ex  input  1  execute-stage stall request.
- stallreq_mem  input  1  memory stage busy (outstanding bus access).
- exc_req_i  input  1  exception request; held high until acknowledged.
- eret_req_i  input  1  ERET request; held high until acknowledged.
- epc_i  input  32  return address used for ERET.
- exc_ack_o  output  1  one-cycle acknowledge of an accepted exception or ERET.
- stall  output  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold.
- flush  output  1  pipeline flush, registered.
- new_pc  output  32  redirect address, valid while flush=1, registered.
- busy_o  output  1  high whenever the FSM is not in RUN.
- stall_cycles_o  output  32  stall-cycle count (see Optional Feature).

Behaviour:
- Reset: state=RUN; flush=0, new_pc=0, exc_ack_o=0, busy_o=0, stall_cycles_o=0. stall is combinational and evaluates per the RUN rules.
- The clock and reset are decided exactly as follows: one clock; reset is asynchronous and active-high.
- Stall encoding in RUN (combinational, highest requester wins):
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 6'b000000
- FSM states: RUN, QUIESCE, FLUSH, RECOVER.
- RUN:
  - If exc_req_i or eret_req_i is high and stallreq_mem=0: accept. Pulse exc_ack_o this cycle, latch target (exception → EXC_VECTOR, else epc_i), drive stall=6'b111111 this cycle, go to FLUSH.
  - If a request is high and stallreq_mem=1: no ack; go to QUIESCE.
- QUIESCE:
  - stall=6'b111111 and busy_o=1.
  - Wait until stallreq_mem=0, then accept exactly as in RUN (ack pulse, latch target, go to FLUSH).
  - If the request drops before acceptance, return to RUN (spurious request; no ack).
- FLUSH:
  - Exactly one cycle: flush=1, new_pc=latched target, stall=6'b000000.
  - Go to RECOVER.
- RECOVER:
  - Lasts RECOVER_CYC cycles, counted with a 3-bit down-counter.
  - Stall encoding as in RUN; requests are not accepted.
  - Go to RUN when the counter reaches 0.
- Latency: acceptance cycle N → flush=1 in cycle N+1; the PC holds new_pc from N+2.
- Simultaneous exc_req_i and eret_req_i: the exception wins and EXC_VECTOR is used. The ERET stays pending and is accepted after RECOVER.
- Requests arriving in FLUSH or RECOVER: ignored until RUN; the requester keeps holding them.
- Reset asserted mid-sequence: immediate return to RUN. Any latched target is discarded; flush drops asynchronously.
- new_pc keeps its last value outside FLUSH; consumers qualify it with flush.

Optional Feature:
- Macro: PIPE_CTRL_STALL_CNT_EN.
- Defined:
  - stall_cycles_o is a 32-bit counter that increments every cycle stall[0]=1.
  - It saturates at 32'hFFFFFFFF and clears on reset.
- Undefined: stall_cycles_o is tied to 0 and no counter flops are inferred.

Decomposition:
- Shared define header holds:
  - stall encodings: STALL_NONE, STALL_IF, STALL_ID, STALL_EX, STALL_MEM, STALL_ALL;
  - FSM state codes, 2-bit;
  - default EXC_VECTOR.
- One natural sub-module: pipe_stall_cnt, the saturating counter, instantiated only under PIPE_CTRL_STALL_CNT_EN.

Test Plan:
- Reset applied then released with stallreq_ex=1 → stall=6'b001111, flush=0, busy_o=0; release stallreq_ex → stall=6'b000000.
- exc_req_i=1 with stallreq_mem=0 in cycle N → exc_ack_o=1 and stall=6'b111111 in N; flush=1 and new_pc=32'hBFC00380 in N+1; RECOVER in N+2; RUN in N+3.
- eret_req_i=1 with epc_i=32'h8000_1234 while stallreq_mem=1 for 4 cycles → stall=6'b111111, busy_o=1, no ack; ack in the cycle stallreq_mem falls; then flush=1 with new_pc=32'h8000_1234.
- exc_req_i and eret_req_i both high → first flush uses 32'hBFC00380; the ERET ack comes only after RECOVER, followed by a second flush to epc_i.
- Reset asserted in QUIESCE and again in FLUSH → flush=0 and state=RUN immediately; no ack is emitted after release unless the request is still held.
- With PIPE_CTRL_STALL_CNT_EN, hold stallreq_if for 10 cycles → stall_cycles_o=10. Without the macro → stall_cycles_o stays 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: stall encodings, FSM state codes
// and the default exception vector.
package pipe_ctrl_pkg;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_ALL  = 6'b111111;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_QUIESCE = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_RECOVER = 2'd3
    } state_e;

    // The deepest requesting stage freezes itself and everything upstream of it.
    function automatic logic [5:0] stall_prio(input logic s_if, input logic s_id,
                                              input logic s_ex, input logic s_mem);
        if (s_mem)     return STALL_MEM;
        else if (s_ex) return STALL_EX;
        else if (s_id) return STALL_ID;
        else if (s_if) return STALL_IF;
        else           return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_stall_cnt.sv
// Saturating 32-bit event counter; counts cycles in which inc_i is high.
module pipe_stall_cnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc_i,
    output logic [31:0] count_o
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != 32'hFFFF_FFFF))
            count_d = count_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall merging, exception/ERET handshake, flush and redirect.
// Optional stall-cycle counter enabled by defining PIPE_CTRL_STALL_CNT_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEF,
    parameter int unsigned RECOVER_CYC = 1
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        exc_req_i,
    input  logic        eret_req_i,
    input  logic [31:0] epc_i,
    output logic        exc_ack_o,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        busy_o,
    output logic [31:0] stall_cycles_o
);

    localparam logic [2:0] RECOVER_LAST = 3'(RECOVER_CYC - 1);

    state_e      state_q;
    logic [2:0]  rec_cnt_q;
    logic        flush_q;
    logic [31:0] new_pc_q;
    logic        req;
    logic        accept;
    logic [5:0]  run_stall;

    always_comb begin
        req       = exc_req_i | eret_req_i;
        // Reset masks acceptance so a held request is not acked while reset is asserted.
        accept    = !reset && req && !stallreq_mem &&
                    ((state_q == ST_RUN) || (state_q == ST_QUIESCE));
        run_stall = stall_prio(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
        stall     = run_stall;
        unique case (state_q)
            ST_RUN:     stall = accept ? STALL_ALL : run_stall;
            ST_QUIESCE: stall = STALL_ALL;
            ST_FLUSH:   stall = STALL_NONE;
            ST_RECOVER: stall = run_stall;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_RUN;
            rec_cnt_q <= '0;
            flush_q   <= 1'b0;
            new_pc_q  <= '0;
        end else begin
            flush_q <= 1'b0;
            unique case (state_q)
                ST_RUN, ST_QUIESCE: begin
                    if (accept) begin
                        state_q  <= ST_FLUSH;
                        flush_q  <= 1'b1;
                        new_pc_q <= exc_req_i ? EXC_VECTOR : epc_i;
                    end else if (!req) begin
                        state_q <= ST_RUN;
                    end else if (stallreq_mem) begin
                        state_q <= ST_QUIESCE;
                    end
                end
                ST_FLUSH: begin
                    state_q   <= ST_RECOVER;
                    rec_cnt_q <= RECOVER_LAST;
                end
                ST_RECOVER: begin
                    if (rec_cnt_q == 3'd0)
                        state_q <= ST_RUN;
                    else
                        rec_cnt_q <= rec_cnt_q - 3'd1;
                end
            endcase
        end
    end

    assign exc_ack_o = accept;
    assign flush     = flush_q;
    assign new_pc    = new_pc_q;
    assign busy_o    = (state_q != ST_RUN);

`ifdef PIPE_CTRL_STALL_CNT_EN
    pipe_stall_cnt u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (stall[0]),
        .count_o (stall_cycles_o)
    );
`else
    assign stall_cycles_o = 32'd0;
`endif

endmodule
